adder4_seq_ctrl: RTL



---
 rtl/adder4_seq_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/adder4_seq_ctrl.sv
// Nibble-serial WIDTH-bit adder built around one 4-bit CLA, with valid/ready on both sides.
// Optional subtract mode is enabled by defining ADDSEQ_SUB_EN.

module adder4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c0,
    output logic [3:0] s,
    output logic       cout
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = c0;
        c[1] = g[0] | (p[0] & c0);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & c0);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & c0);
        s    = p ^ c[3:0];
        cout = c[4];
    end
endmodule

module adder4_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
`ifdef ADDSEQ_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    localparam int NIB = WIDTH / 4;
    localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

    generate
        if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
            $error("adder4_seq_ctrl: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t            state;
    state_t            nxt;
    logic [IW-1:0]     idx;
    logic              carry;
    logic [WIDTH-1:0]  a_reg;
    logic [WIDTH-1:0]  b_reg;
    logic [WIDTH-1:0]  sum_reg;
    logic [3:0]        nib_s;
    logic              nib_c;
    logic              accept;
    logic              last;
    logic [WIDTH-1:0]  b_load;
    logic              c_load;

    adder4 u_add (
        .a    (a_reg[{idx, 2'b00} +: 4]),
        .b    (b_reg[{idx, 2'b00} +: 4]),
        .c0   (carry),
        .s    (nib_s),
        .cout (nib_c)
    );

    // Subtract is a + ~b + 1, so b is stored already inverted.
`ifdef ADDSEQ_SUB_EN
    assign b_load = in_sub ? ~in_b : in_b;
    assign c_load = in_sub ? 1'b1 : in_cin;
`else
    assign b_load = in_b;
    assign c_load = in_cin;
`endif

    assign accept = in_valid && in_ready;
    assign last   = (idx == IW'(NIB - 1));

    always_comb begin
        nxt       = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nxt = BUSY;
            end
            BUSY: begin
                busy = 1'b1;
                if (last) nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            carry   <= 1'b0;
            a_reg   <= '0;
            b_reg   <= '0;
            sum_reg <= '0;
        end else begin
            state <= nxt;
            if (accept) begin
                a_reg   <= in_a;
                b_reg   <= b_load;
                carry   <= c_load;
                idx     <= '0;
                sum_reg <= '0;
            end else if (state == BUSY) begin
                sum_reg[{idx, 2'b00} +: 4] <= nib_s;
                carry <= nib_c;
                idx   <= last ? '0 : idx + IW'(1);
            end
        end
    end

    assign out_sum  = sum_reg;
    assign out_cout = carry;
    assign out_ovf  = (state == DONE)
                   && (a_reg[WIDTH-1] == b_reg[WIDTH-1])
                   && (sum_reg[WIDTH-1] != a_reg[WIDTH-1]);
endmodule
